// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes and FSM states.
package alu_seq_pkg;

  // Operation select encoding.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per clock,
// WIDTH steps per operation. The first step is taken on the start edge, so
// the done pulse follows WIDTH-1 cycles later with hi/lo already final.
// mul: {hi, lo} = a * b.  div: lo = a / b, hi = a % b (b == 0 gives lo = all
// ones, hi = a).
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy;
  logic             div_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;

  // One iteration on the {hi, lo} accumulator pair.
  function automatic logic [2*WIDTH-1:0] step(
    input logic [WIDTH-1:0] h,
    input logic [WIDTH-1:0] l,
    input logic [WIDTH-1:0] d,
    input logic             div
  );
    logic [WIDTH:0] wide;
    logic           ge;
    if (div) begin
      wide = {h, l[WIDTH-1]};
      ge   = (wide >= {1'b0, d});
      if (ge) wide = wide - {1'b0, d};
      step = {wide[WIDTH-1:0], l[WIDTH-2:0], ge};
    end else begin
      wide = {1'b0, h} + {1'b0, d & {WIDTH{l[0]}}};
      step = {wide, l[WIDTH-1:1]};
    end
  endfunction

  // Load-and-first-step on start, then iterate; cnt counts completed steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      div_q <= 1'b0;
      b_q   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {hi, lo} <= step('0, a, b, is_div);
        b_q      <= b;
        div_q    <= is_div;
        cnt      <= CW'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        {hi, lo} <= step(hi, lo, b_q, div_q);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: valid/ready FSM, single-cycle add/sub, flag generation
// and registered result. Define ALU_SEQ_MULDIV_EN to include the iterative
// multiply/divide engine; without it mul/div complete at once with err = 1.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic             err
);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             load;
  logic             start;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res_out;
  logic [WIDTH-1:0] res_rem;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] a_q;
  logic             bz_q;
  logic             div_q;
  logic             is_div;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  assign is_div = (select == OP_DIV);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Operand context needed when the engine result is finalised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      bz_q  <= 1'b0;
      div_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      bz_q  <= (b == '0);
      div_q <= is_div;
    end
  end
`else
  assign start = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state; load marks the DONE entry edge, start kicks the engine.
  always_comb begin
    state_n = state;
    load    = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    start   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (select == OP_ADD || select == OP_SUB) begin
            state_n = DONE;
            load    = 1'b1;
          end else begin
`ifdef ALU_SEQ_MULDIV_EN
            state_n = BUSY;
            start   = 1'b1;
`else
            state_n = DONE;
            load    = 1'b1;
`endif
          end
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      BUSY: begin
        if (md_done) begin
          state_n = DONE;
          load    = 1'b1;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result selection: live inputs for add/sub, engine output for mul/div.
  always_comb begin
    wide      = '0;
    res_out   = '0;
    res_rem   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    if (state == IDLE) begin
      case (select)
        OP_ADD: begin
          wide      = {1'b0, a} + {1'b0, b};
          res_out   = wide[WIDTH-1:0];
          res_carry = wide[WIDTH];
          res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          wide      = {1'b0, a} - {1'b0, b};
          res_out   = wide[WIDTH-1:0];
          res_carry = wide[WIDTH];
          res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        end
        // Only loaded from here when the engine is absent.
        default: res_err = 1'b1;
      endcase
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (state == BUSY) begin
      if (div_q && bz_q) begin
        res_out = '1;
        res_rem = a_q;
        res_err = 1'b1;
      end else begin
        res_out   = md_lo;
        res_rem   = md_hi;
        res_carry = !div_q && (md_hi != '0);
      end
    end
`endif
  end

  // Output registers; result and flags change only on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      rem       <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      sign      <= 1'b0;
      parity    <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (load) begin
        out      <= res_out;
        rem      <= res_rem;
        zero     <= ~|res_out;
        carry    <= res_carry;
        sign     <= res_out[WIDTH-1];
        parity   <= ~^res_out;
        overflow <= res_ovf;
        err      <= res_err;
      end
    end
  end

endmodule
